mips_cpu_mc_sequencer: RTL and testbench
========================================

Name: mips_cpu_mc_sequencer

Overview:
- Multicycle control FSM for the MIPS CPU. It sequences each instruction through fetch, decode, execute, memory and writeback around the shared 32-bit ALU and the single Avalon-style memory port.
- It holds the latched opcode/funct and drives them onto the ALU's opcode and ALU_control inputs. It generates all datapath enables and implements the branch delay slot.
- Halt: the sequencer stops when the PC reaches address 0.

Parameters:
- HALT_ON_ILLEGAL, 1, 1 = unsupported instruction forces HALT with illegal=1; 0 = treat it as a NOP.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- instr_word  input  32  IR contents, valid from DECODE onward
- sig_branch  input  1  ALU branch-taken flag, valid in EXEC
- pc_is_zero  input  1  current PC == 0x00000000
- waitrequest  input  1  memory stall
- active  output  1  CPU running
- illegal  output  1  sticky illegal-instruction flag
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- addr_sel  output  1  0 = PC, 1 = ALU_result drives the address
- ir_write  output  1  load IR from readdata
- pc_write  output  1  update PC
- pc_src  output  2  00 PC+4, 01 branch target, 10 jump target, 11 rs
- target_latch  output  1  datapath captures the pending target
- alu_opcode  output  6  to ALU opcode
- alu_control  output  6  to ALU ALU_control
- reg_write  output  1  register file write enable
- reg_dst  output  2  00 rt, 01 rd, 10 $31
- mem_to_reg  output  1  writeback data: 1 = readdata, 0 = ALU_result/link

Behaviour:
- Reset (reset==0 at posedge):
  - state = FETCH; op_q, funct_q, pending, pend_src = 0; active = 1; illegal = 0.
  - All strobes and enables are 0; alu_opcode and alu_control are 0.
  - Reset wins over every other event. A reset during MEM drops mem_read/mem_write in the same cycle.
- Output timing:
  - Strobes (mem_read, mem_write, ir_write, pc_write, reg_write, target_latch) are Moore outputs, decoded from the state register plus op_q/pending.
  - Only the waitrequest and sig_branch qualifications are combinational.
- FETCH:
  - If pc_is_zero, go to HALT.
  - Otherwise assert mem_read with addr_sel = 0.
  - While waitrequest = 1, stay in FETCH and hold mem_read.
  - On waitrequest = 0, pulse ir_write and go to DECODE.
- DECODE:
  - Latch op_q = instr_word[31:26] and funct_q = instr_word[5:0].
  - Classify the instruction, then go to EXEC.
  - Supported R-type funct values: 21, 23, 24, 25, 26, 00, 02, 03, 2B, 08 (jr).
  - Supported opcodes: 09, 0A, 0B, 0C, 0D, 0E, 0F, 04, 05, 02 (j), 03 (jal), 23 (lw), 2B (sw).
  - Anything else: set illegal = 1 (sticky); go to HALT if HALT_ON_ILLEGAL, else go to FETCH with pc_write (NOP).
- EXEC:
  - alu_opcode = op_q; alu_control = funct_q.
  - ALU ops: go to WRITEBACK.
  - lw/sw: go to MEM.
  - beq/bne: pulse target_latch; pending = sig_branch; pend_src = 01; pc_write; go to FETCH.
  - j/jal/jr: pulse target_latch; pending = 1; pend_src = 10 for j/jal, 11 for jr.
    - j and jr: pc_write, go to FETCH.
    - jal: go to WRITEBACK for the link write.
- MEM:
  - addr_sel = 1.
  - mem_read asserted for lw, mem_write for sw; the strobe is held while waitrequest = 1.
  - On release: lw goes to WRITEBACK; sw does pc_write and goes to FETCH.
- WRITEBACK:
  - reg_write = 1; pc_write = 1; then go to FETCH.
  - mem_to_reg = 1 only for lw.
  - reg_dst = 01 for R-type, 10 for jal, 00 otherwise.
- PC update and delay slot (every pc_write):
  - pc_src = pend_src if pending was already set before the current instruction; otherwise pc_src = 00.
  - If pending was set before the current instruction, pending clears after the write.
  - A jump or taken branch sets pending for the next instruction, so the delay-slot instruction executes first.
  - Branch in a delay slot: its pc_write consumes the old pending, then its own decision sets the new pending.
- HALT: absorbing state; active = 0; all strobes are 0. Only reset exits.
- Latency with zero waitrequest:
  - ALU instruction: 4 cycles.
  - lw: 5 cycles.
  - sw, jal: 4 cycles.
  - beq, bne, j, jr: 3 cycles.
  - Each waitrequest cycle adds 1 cycle.

Test Plan:
- reset = 0 for 2 cycles, then addu (000000 ... 100001), waitrequest = 0 -> cycle-by-cycle trace:
  - cycle 1: mem_read, then ir_write.
  - cycle 4: reg_write = 1, reg_dst = 01, pc_src = 00.
  - Instruction completes in 4 cycles.
- lw with waitrequest = 1 for 3 cycles in MEM -> mem_read and addr_sel = 1 held for 4 cycles; then reg_write with mem_to_reg = 1. Total 8 cycles.
- beq with sig_branch = 1, followed by ori -> beq's pc_write uses pc_src = 00; ori's WRITEBACK uses pc_src = 01; pending = 0 afterwards.
- beq with sig_branch = 0 -> the next instruction uses pc_src = 00.
- jal, then delay slot, then pc_is_zero = 1 at FETCH:
  - jal WRITEBACK: reg_dst = 10.
  - Delay-slot instruction: pc_src = 10.
  - At FETCH with pc_is_zero: HALT, active = 0, no further mem_read.
- Opcode 0x3F with HALT_ON_ILLEGAL = 1 -> illegal = 1 and HALT.
- Reset asserted mid-MEM of sw -> mem_write = 0 the next cycle, state FETCH, illegal and pending cleared.

Source files
------------

// File: rtl/mips_cpu_mc_sequencer.sv
// rtl/mips_cpu_mc_sequencer.sv - multicycle MIPS control sequencer with branch delay slot
module mips_cpu_mc_sequencer #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_word,
    input  logic        sig_branch,
    input  logic        pc_is_zero,
    input  logic        waitrequest,
    output logic        active,
    output logic        illegal,
    output logic        mem_read,
    output logic        mem_write,
    output logic        addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        target_latch,
    output logic [5:0]  alu_opcode,
    output logic [5:0]  alu_control,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic        mem_to_reg
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t      r_state;
    logic [5:0]  r_op;
    logic [5:0]  r_funct;
    logic        r_pending;
    logic [1:0]  r_pend_src;
    logic        r_illegal;

    logic        w_dec_ok;
    logic        w_is_rtype;
    logic        w_is_jr;
    logic        w_is_branch;
    logic        w_is_j;
    logic        w_is_jal;
    logic        w_is_lw;
    logic        w_is_sw;
    logic        w_new_pend;
    logic [1:0]  w_new_src;
    logic        w_unused_bits;

    // Register fields and shift amount are consumed by the datapath, not here
    assign w_unused_bits = ^instr_word[25:6];

    function automatic logic f_supported(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        ok = 1'b0;
        if (op == 6'h00) begin
            case (fn)
                6'h21, 6'h23, 6'h24, 6'h25, 6'h26,
                6'h00, 6'h02, 6'h03, 6'h2B, 6'h08: ok = 1'b1;
                default:                           ok = 1'b0;
            endcase
        end else begin
            case (op)
                6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                6'h04, 6'h05, 6'h02, 6'h03, 6'h23, 6'h2B: ok = 1'b1;
                default:                                 ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    assign w_dec_ok    = f_supported(instr_word[31:26], instr_word[5:0]);
    assign w_is_rtype  = (r_op == 6'h00);
    assign w_is_jr     = w_is_rtype && (r_funct == 6'h08);
    assign w_is_branch = (r_op == 6'h04) || (r_op == 6'h05);
    assign w_is_j      = (r_op == 6'h02);
    assign w_is_jal    = (r_op == 6'h03);
    assign w_is_lw     = (r_op == 6'h23);
    assign w_is_sw     = (r_op == 6'h2B);

    assign active      = (r_state != S_HALT);
    assign illegal     = r_illegal;
    assign alu_opcode  = r_op;
    assign alu_control = r_funct;

    // Pending redirect that the current instruction arms for its successor;
    // committed on the same edge as its own pc_write, which consumes the old one
    always_comb begin
        w_new_pend = 1'b0;
        w_new_src  = 2'b00;
        if (r_state == S_EXEC) begin
            if (w_is_branch) begin
                w_new_pend = sig_branch;
                w_new_src  = sig_branch ? 2'b01 : 2'b00;
            end else if (w_is_j) begin
                w_new_pend = 1'b1;
                w_new_src  = 2'b10;
            end else if (w_is_jr) begin
                w_new_pend = 1'b1;
                w_new_src  = 2'b11;
            end
        end else if ((r_state == S_WB) && w_is_jal) begin
            w_new_pend = 1'b1;
            w_new_src  = 2'b10;
        end
    end

    // Moore strobe decode; reset forces every strobe low immediately
    always_comb begin
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        addr_sel     = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        target_latch = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 2'b00;
        mem_to_reg   = 1'b0;
        pc_src       = r_pending ? r_pend_src : 2'b00;
        case (r_state)
            S_FETCH: begin
                if (!pc_is_zero) begin
                    mem_read = 1'b1;
                    ir_write = !waitrequest;
                end
            end
            S_DECODE: begin
                if (!w_dec_ok && !HALT_ON_ILLEGAL) pc_write = 1'b1;
            end
            S_EXEC: begin
                if (w_is_branch || w_is_j || w_is_jr) begin
                    target_latch = 1'b1;
                    pc_write     = 1'b1;
                end else if (w_is_jal) begin
                    target_latch = 1'b1;
                end
            end
            S_MEM: begin
                addr_sel  = 1'b1;
                mem_read  = w_is_lw;
                mem_write = w_is_sw;
                pc_write  = w_is_sw && !waitrequest;
            end
            S_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                mem_to_reg = w_is_lw;
                reg_dst    = w_is_rtype ? 2'b01 : (w_is_jal ? 2'b10 : 2'b00);
            end
            default: ;
        endcase
        if (!reset) begin
            mem_read     = 1'b0;
            mem_write    = 1'b0;
            addr_sel     = 1'b0;
            ir_write     = 1'b0;
            pc_write     = 1'b0;
            target_latch = 1'b0;
            reg_write    = 1'b0;
            reg_dst      = 2'b00;
            mem_to_reg   = 1'b0;
            pc_src       = 2'b00;
        end
    end

    // State sequencing, instruction latch, sticky illegal and delay-slot tracking
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_FETCH;
            r_op       <= 6'h00;
            r_funct    <= 6'h00;
            r_pending  <= 1'b0;
            r_pend_src <= 2'b00;
            r_illegal  <= 1'b0;
        end else begin
            if (pc_write) begin
                r_pending  <= w_new_pend;
                r_pend_src <= w_new_src;
            end
            case (r_state)
                S_FETCH: begin
                    if (pc_is_zero)        r_state <= S_HALT;
                    else if (!waitrequest) r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_op    <= instr_word[31:26];
                    r_funct <= instr_word[5:0];
                    if (w_dec_ok) begin
                        r_state <= S_EXEC;
                    end else begin
                        r_illegal <= 1'b1;
                        r_state   <= HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                    end
                end
                S_EXEC: begin
                    if (w_is_lw || w_is_sw)                    r_state <= S_MEM;
                    else if (w_is_branch || w_is_j || w_is_jr) r_state <= S_FETCH;
                    else                                       r_state <= S_WB;
                end
                S_MEM: begin
                    if (!waitrequest) r_state <= w_is_lw ? S_WB : S_FETCH;
                end
                S_WB:    r_state <= S_FETCH;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_mc_sequencer.sv
// tb/tb_mips_cpu_mc_sequencer.sv - scoreboard bench for the multicycle sequencer
module tb_mips_cpu_mc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr_word = 32'h0;
    logic        sig_branch = 1'b0;
    logic        pc_is_zero = 1'b0;
    logic        waitrequest = 1'b0;
    logic        active, illegal, mem_read, mem_write, addr_sel, ir_write, pc_write;
    logic        target_latch, reg_write, mem_to_reg;
    logic [1:0]  pc_src, reg_dst;
    logic [5:0]  alu_opcode, alu_control;

    mips_cpu_mc_sequencer #(.HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .reset(reset), .instr_word(instr_word), .sig_branch(sig_branch),
        .pc_is_zero(pc_is_zero), .waitrequest(waitrequest), .active(active),
        .illegal(illegal), .mem_read(mem_read), .mem_write(mem_write),
        .addr_sel(addr_sel), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .target_latch(target_latch), .alu_opcode(alu_opcode),
        .alu_control(alu_control), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic       mem_to_reg;
        int         cycles;
    } exp_t;

    exp_t       sb_q[$];
    bit         m_pend = 1'b0;
    logic [1:0] m_src = 2'b00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
        return {op, 5'd1, 5'd2, 5'd3, 5'd0, fn};
    endfunction

    // Hold reset low two edges, check the reset state, release within a FETCH cycle
    task automatic do_reset();
        reset = 1'b0;
        waitrequest = 1'b0;
        pc_is_zero = 1'b0;
        m_pend = 1'b0;
        m_src = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_active", active, 1);
        check("rst_illegal", illegal, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_pc_write", pc_write, 0);
        check("rst_alu_opcode", alu_opcode, 0);
        reset = 1'b1;
    endtask

    // Push the expected retirement, then act as memory until pc_write retires it
    task automatic run_instr(input string tag, input logic [31:0] w, input int mwait, input bit br);
        exp_t       e;
        exp_t       g;
        logic [5:0] op;
        logic [5:0] fn;
        bit         nset;
        logic [1:0] nsrc;
        int         cyc;
        int         hold;
        int         left;
        bit         done;
        op = w[31:26];
        fn = w[5:0];
        nset = 1'b0;
        nsrc = 2'b00;
        e.pc_src = m_pend ? m_src : 2'b00;
        e.reg_write = 1'b1;
        e.reg_dst = 2'b00;
        e.mem_to_reg = 1'b0;
        e.cycles = 4;
        if (op == 6'h00 && fn == 6'h08) begin
            e.reg_write = 1'b0; e.cycles = 3; nset = 1'b1; nsrc = 2'b11;
        end else if (op == 6'h00) begin
            e.reg_dst = 2'b01;
        end else if (op == 6'h04 || op == 6'h05) begin
            e.reg_write = 1'b0; e.cycles = 3; nset = br; nsrc = 2'b01;
        end else if (op == 6'h02) begin
            e.reg_write = 1'b0; e.cycles = 3; nset = 1'b1; nsrc = 2'b10;
        end else if (op == 6'h03) begin
            e.reg_dst = 2'b10; nset = 1'b1; nsrc = 2'b10;
        end else if (op == 6'h23) begin
            e.mem_to_reg = 1'b1; e.cycles = 5 + mwait;
        end else if (op == 6'h2B) begin
            e.reg_write = 1'b0; e.cycles = 4 + mwait;
        end
        m_pend = nset;
        m_src = nsrc;
        sb_q.push_back(e);

        instr_word = w;
        sig_branch = br;
        cyc = 0;
        hold = 0;
        left = mwait;
        done = 1'b0;
        while (!done && cyc < 40) begin
            waitrequest = addr_sel && (mem_read || mem_write) && (left > 0);
            if (waitrequest) left--;
            #4;
            cyc++;
            if (addr_sel && (mem_read || mem_write)) hold++;
            if (cyc == 1) begin
                check({tag, "_fetch_rd"}, mem_read, 1);
                check({tag, "_fetch_ir"}, ir_write, 1);
            end
            if (cyc == 3) begin
                check({tag, "_alu_op"}, alu_opcode, op);
                check({tag, "_alu_ctl"}, alu_control, fn);
            end
            if (pc_write) begin
                done = 1'b1;
                if (sb_q.size() == 0) begin
                    check({tag, "_sb_empty"}, 0, 1);
                end else begin
                    g = sb_q.pop_front();
                    check({tag, "_pc_src"}, pc_src, g.pc_src);
                    check({tag, "_reg_write"}, reg_write, g.reg_write);
                    check({tag, "_reg_dst"}, reg_dst, g.reg_dst);
                    check({tag, "_mem_to_reg"}, mem_to_reg, g.mem_to_reg);
                    check({tag, "_cycles"}, cyc, g.cycles);
                end
            end
            @(posedge clk);
            #1;
        end
        if (!done) check({tag, "_timeout"}, 0, 1);
        if (op == 6'h23 || op == 6'h2B) check({tag, "_mem_hold"}, hold, mwait + 1);
        waitrequest = 1'b0;
    endtask

    int n;

    initial begin
        do_reset();
        run_instr("addu", mk(6'h00, 6'h21), 0, 1'b0);
        run_instr("lw", mk(6'h23, 6'h04), 3, 1'b0);
        run_instr("beq_t", mk(6'h04, 6'h02), 0, 1'b1);
        run_instr("ori_ds", mk(6'h0D, 6'h0F), 0, 1'b0);
        run_instr("and_after", mk(6'h00, 6'h24), 0, 1'b0);
        run_instr("bne_nt", mk(6'h05, 6'h01), 0, 1'b0);
        run_instr("ori_nt", mk(6'h0D, 6'h03), 0, 1'b0);
        run_instr("sw", mk(6'h2B, 6'h08), 1, 1'b0);
        run_instr("jr", mk(6'h00, 6'h08), 0, 1'b0);
        run_instr("jr_ds", mk(6'h00, 6'h25), 0, 1'b0);
        run_instr("jal", mk(6'h03, 6'h10), 0, 1'b0);
        run_instr("jal_ds", mk(6'h00, 6'h21), 0, 1'b0);

        // Halt on PC == 0 at FETCH, and stay halted once it drops
        pc_is_zero = 1'b1;
        #4;
        check("halt_no_rd", mem_read, 0);
        @(posedge clk);
        #1;
        pc_is_zero = 1'b0;
        check("halt_active", active, 0);
        repeat (3) @(posedge clk);
        #1;
        check("halt_sticky", active, 0);
        check("halt_rd_after", mem_read, 0);

        // Unsupported opcode halts with the sticky flag
        do_reset();
        instr_word = {6'h3F, 26'h0};
        n = 0;
        while (n < 10) begin
            #4;
            n++;
            if (!active) break;
            @(posedge clk);
            #1;
        end
        check("ill_cycles", n, 3);
        check("ill_flag", illegal, 1);
        check("ill_active", active, 0);

        // Reset in the middle of a stalled store, with a jump pending
        do_reset();
        check("ill_cleared", illegal, 0);
        run_instr("j", mk(6'h02, 6'h00), 0, 1'b0);
        instr_word = mk(6'h2B, 6'h00);
        n = 0;
        while (!addr_sel && n < 10) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("sw_mem_reached", addr_sel, 1);
        waitrequest = 1'b1;
        #4;
        check("sw_wr_held", mem_write, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #4;
        check("rst_mid_wr", mem_write, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        waitrequest = 1'b0;
        m_pend = 1'b0;
        m_src = 2'b00;
        #4;
        check("post_rst_wr", mem_write, 0);
        check("post_rst_fetch", mem_read, 1);
        check("post_rst_ill", illegal, 0);
        @(posedge clk);
        #1;
        // Back in FETCH for the next instruction: redo the reset cleanly so it is aligned
        do_reset();
        run_instr("addu_post", mk(6'h00, 6'h23), 0, 1'b0);
        check("sb_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
